// File: rtl/hamming_enc_engine.sv
// SECDED (15,11)+overall-parity encoder engine: reads N_MSG messages from data memory
// and writes one 16-bit codeword per message. Optional macro: HAMMING_ENC_STRICT_EN.
module hamming_enc_engine #(
    parameter int N_MSG    = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          busy,
    output logic          done,
    output logic          fmt_err
);

    localparam int IW = (N_MSG > 1) ? $clog2(N_MSG) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_WR_LO = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   cw_q, cw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [11:1]   d;
    logic          p8, p4, p2, p1, p0;
    logic [15:0]   cw_calc;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          last_msg;

    // Hi byte arrives on the read bus during CAPT; lo byte was latched in RD_HI.
    assign d = {mem_rd_data[2:0], lo_q};

    always_comb begin
        p8      = ^d[11:5];
        p4      = (^d[11:8]) ^ (^d[4:2]);
        p2      = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1      = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0      = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        cw_calc = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    end

    assign src_addr = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
    assign dst_addr = AW'(DST_BASE) + AW'({idx_q, 1'b0});
    assign last_msg = (idx_q == IW'(N_MSG - 1));

`ifdef HAMMING_ENC_STRICT_EN
    logic fmt_q, fmt_d;
    assign fmt_err = fmt_q;
`else
    logic unused_hi_bits;
    assign unused_hi_bits = ^mem_rd_data[7:3];
    assign fmt_err        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        cw_d        = cw_q;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef HAMMING_ENC_STRICT_EN
        fmt_d       = fmt_q;
`endif
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_LO;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
`ifdef HAMMING_ENC_STRICT_EN
                    fmt_d   = 1'b0;
`endif
                end
            end
            S_RD_LO: begin
                mem_addr = src_addr;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr = src_addr + AW'(1);
                lo_d     = mem_rd_data;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                cw_d    = cw_calc;
`ifdef HAMMING_ENC_STRICT_EN
                if (mem_rd_data[7:3] != 5'b00000) fmt_d = 1'b1;
`endif
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr    = dst_addr + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cw_q[15:8];
                state_d     = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = cw_q[7:0];
                if (last_msg) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_RD_LO;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            cw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef HAMMING_ENC_STRICT_EN
            fmt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            cw_q    <= cw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef HAMMING_ENC_STRICT_EN
            fmt_q   <= fmt_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine with a 1-cycle-latency byte memory model.
// Codewords are checked against hand-computed constants and an independent syndrome decode.
module tb_hamming_enc_engine;

    localparam int N_MSG = 15;
    localparam int SRC   = 0;
    localparam int DST   = 30;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [7:0]    mem_rd_data;
    logic          busy;
    logic          done;
    logic          fmt_err;

    logic [7:0]    mem [0:255];
    int unsigned   wr_cnt = 0;
    logic          tb_we = 1'b0;
    logic [7:0]    tb_addr = '0;
    logic [7:0]    tb_data = '0;

    logic [7:0]    lo_v [N_MSG];
    logic [7:0]    hi_v [N_MSG];

    int total = 0;
    int bad   = 0;

    hamming_enc_engine #(
        .N_MSG(N_MSG),
        .SRC_BASE(SRC),
        .DST_BASE(DST),
        .AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .busy(busy),
        .done(done),
        .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (tb_we) begin
            mem[tb_addr] = tb_data;
        end else if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    // {overall parity, 4-bit syndrome}; zero for a clean codeword
    function automatic logic [4:0] syndrome(input logic [15:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) s = s ^ 4'(k);
        return {^cw, s};
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        tb_addr = 8'(a);
        tb_data = v;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic load_msgs;
        for (int i = 0; i < N_MSG; i++) begin
            poke(SRC + 2*i, lo_v[i]);
            poke(SRC + 2*i + 1, hi_v[i]);
        end
    endtask

    task automatic clear_dst;
        for (int i = 0; i < 2*N_MSG; i++) poke(DST + i, 8'hAA);
    endtask

    // Pulses start; returns the cycle (start cycle = 0) at which done is first seen.
    task automatic run_to_done(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (fmt_err !== 1'b0) begin bad++; $display("FAIL reset_fmt got=%b exp=0", fmt_err); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
        total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", mem_wr_en); end
        total++; if (mem_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", mem_wr_data); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored busy got=%b exp=0", busy); end
    endtask

    task automatic test_directed;
        logic [15:0] exp_cw [N_MSG];
        logic [15:0] got;
        int cyc;
        int unsigned w0;
        for (int i = 0; i < N_MSG; i++) begin
            lo_v[i] = 8'h00; hi_v[i] = 8'h00; exp_cw[i] = 16'h0000;
        end
        lo_v[0] = 8'h01; hi_v[0] = 8'h00; exp_cw[0] = 16'h000F;
        lo_v[1] = 8'hFF; hi_v[1] = 8'h07; exp_cw[1] = 16'hFFFF;
        lo_v[2] = 8'h00; hi_v[2] = 8'h00; exp_cw[2] = 16'h0000;
        lo_v[3] = 8'h00; hi_v[3] = 8'h04; exp_cw[3] = 16'h8117;
        lo_v[4] = 8'h02; hi_v[4] = 8'h00; exp_cw[4] = 16'h0033;
        lo_v[5] = 8'h00; hi_v[5] = 8'hF9; exp_cw[5] = 16'h2112;
        lo_v[6] = 8'h80; hi_v[6] = 8'h00; exp_cw[6] = 16'h1111;
        load_msgs();
        clear_dst();
        w0 = wr_cnt;
        run_to_done(cyc);
        total++; if (cyc != 76) begin bad++; $display("FAIL dir_done_cycle got=%0d exp=76", cyc); end
        total++; if (wr_cnt - w0 != 30) begin bad++; $display("FAIL dir_strobes got=%0d exp=30", wr_cnt - w0); end
        total++; if (mem[31] !== 8'h00 || mem[30] !== 8'h0F) begin
            bad++; $display("FAIL dir_mem30_31 got=%h%h exp=000f", mem[31], mem[30]);
        end
        for (int i = 0; i < N_MSG; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            total++; if (got !== exp_cw[i]) begin
                bad++; $display("FAIL dir_cw[%0d] got=%h exp=%h", i, got, exp_cw[i]);
            end
        end
`ifdef HAMMING_ENC_STRICT_EN
        total++; if (fmt_err !== 1'b1) begin bad++; $display("FAIL dir_fmt_err got=%b exp=1", fmt_err); end
`else
        total++; if (fmt_err !== 1'b0) begin bad++; $display("FAIL dir_fmt_err got=%b exp=0", fmt_err); end
`endif
        repeat (3) @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL dir_done_latched got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
    endtask

    task automatic check_cws(input string tag);
        logic [15:0] got;
        logic [4:0]  syn;
        logic [10:0] dx;
        for (int i = 0; i < N_MSG; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            syn = syndrome(got);
            dx  = {got[15:9], got[7:5], got[3]};
            total++; if (syn !== 5'b00000 || dx !== {hi_v[i][2:0], lo_v[i]}) begin
                bad++; $display("FAIL %s_cw[%0d] got=%h syn=%b data=%h exp data=%h syn=0",
                                tag, i, got, syn, dx, {hi_v[i][2:0], lo_v[i]});
            end
        end
    endtask

    task automatic test_full_run;
        logic [31:0] r;
        int cyc;
        int unsigned w0;
        logic src_ok;
        for (int i = 0; i < N_MSG; i++) begin
            r = $urandom;
            lo_v[i] = r[7:0];
            hi_v[i] = {5'b00000, r[10:8]};
        end
        load_msgs();
        clear_dst();
        w0 = wr_cnt;
        run_to_done(cyc);
        total++; if (cyc != 76) begin bad++; $display("FAIL full_done_cycle got=%0d exp=76", cyc); end
        total++; if (wr_cnt - w0 != 30) begin bad++; $display("FAIL full_strobes got=%0d exp=30", wr_cnt - w0); end
        check_cws("full");
        src_ok = 1'b1;
        for (int i = 0; i < N_MSG; i++)
            if (mem[SRC + 2*i] !== lo_v[i] || mem[SRC + 2*i + 1] !== hi_v[i]) src_ok = 1'b0;
        total++; if (src_ok !== 1'b1) begin bad++; $display("FAIL full_src_unchanged got=%b exp=1", src_ok); end
        total++; if (fmt_err !== 1'b0) begin bad++; $display("FAIL full_fmt_cleared got=%b exp=0", fmt_err); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int unsigned w0;
        clear_dst();
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        total++; if (busy !== 1'b1 || mem_addr !== 8'(SRC)) begin
            bad++; $display("FAIL b2b_first_cycle got busy=%b addr=%h exp busy=1 addr=%h", busy, mem_addr, 8'(SRC));
        end
        while (cyc < 30) begin @(negedge clk); cyc++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        total++; if (cyc != 76) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=76", cyc); end
        total++; if (wr_cnt - w0 != 30) begin bad++; $display("FAIL b2b_strobes got=%0d exp=30", wr_cnt - w0); end
        check_cws("b2b");
    endtask

    task automatic test_reset_midrun;
        int cyc;
        int unsigned w0;
        logic saw_wr;
        clear_dst();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin @(negedge clk); cyc++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || mem_wr_en !== 1'b0) begin
            bad++; $display("FAIL midrst_state got busy=%b done=%b wren=%b exp 0 0 0", busy, done, mem_wr_en);
        end
        w0 = wr_cnt;
        saw_wr = 1'b0;
        repeat (20) begin
            if (mem_wr_en !== 1'b0) saw_wr = 1'b1;
            @(negedge clk);
        end
        total++; if (saw_wr !== 1'b0 || wr_cnt != w0) begin
            bad++; $display("FAIL midrst_no_writes got saw=%b writes=%0d exp saw=0 writes=0", saw_wr, wr_cnt - w0);
        end
        total++; if (mem[DST + 20] !== 8'hAA) begin
            bad++; $display("FAIL midrst_untouched got=%h exp=aa", mem[DST + 20]);
        end
        clear_dst();
        w0 = wr_cnt;
        run_to_done(cyc);
        total++; if (cyc != 76) begin bad++; $display("FAIL rerun_done_cycle got=%0d exp=76", cyc); end
        total++; if (wr_cnt - w0 != 30) begin bad++; $display("FAIL rerun_strobes got=%0d exp=30", wr_cnt - w0); end
        check_cws("rerun");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_directed();
        test_full_run();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
